// File: rtl/peripheral_spram_pkg.sv
// Shared types and address helpers for the single-port SRAM memory controller.
package peripheral_spram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } spram_state_t;

  // Widest byte address the range check can carry without truncation.
  localparam int unsigned MAX_ADDR_W = 128;

  function automatic int unsigned word_lsb(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] word_idx(input logic [MAX_ADDR_W-1:0] addr,
                                                     input int unsigned lsb);
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/peripheral_spram_array.sv
// Behavioural byte-enable single-port array with a registered read port.
module peripheral_spram_array #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input  logic                         clk_i,
  input  logic                         en_i,
  input  logic                         we_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] idx_i,
  input  logic [DATA_WIDTH/8-1:0]      be_i,
  input  logic [DATA_WIDTH-1:0]        d_i,
  output logic [DATA_WIDTH-1:0]        q_o
);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // q_o only moves on a read, so it holds across writes and idle cycles.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
          if (be_i[b]) mem[idx_i][8*b +: 8] <= d_i[8*b +: 8];
        end
      end else begin
        q_o <= mem[idx_i];
      end
    end
  end

endmodule

// File: rtl/peripheral_spram_mem_ctrl.sv
// Memory-side stage behind the AXI4 SRAM adapter: post-reset clear, range check,
// sticky error flag and 1-cycle read path into the single-port array.
module peripheral_spram_mem_ctrl
  import peripheral_spram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_DEPTH  = 1024,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    rvalid_o,
  output logic                    ready_o,
  output logic                    err_o,
  input  logic                    err_clr_i
);

  localparam int unsigned WORD_LSB = word_lsb(DATA_WIDTH);
  localparam int unsigned IDX_W    = $clog2(MEM_DEPTH);
  localparam int unsigned BE_W     = DATA_WIDTH / 8;

  spram_state_t          state_q, state_d;
  logic [IDX_W-1:0]      init_cnt_q, init_cnt_d;
  logic                  ready_q, rvalid_q, err_q, rzero_q;
  logic                  err_set, bus_rd;
  logic                  in_range;
  logic [IDX_W-1:0]      bus_idx;
  logic [MAX_ADDR_W-1:0] addr_ext;

  logic                  arr_en, arr_we;
  logic [IDX_W-1:0]      arr_idx;
  logic [BE_W-1:0]       arr_be;
  logic [DATA_WIDTH-1:0] arr_d, arr_q;

  // Full-width compare so high address bits cannot alias onto a valid word.
  assign addr_ext = MAX_ADDR_W'(addr_i);
  assign in_range = word_idx(addr_ext, WORD_LSB) < MAX_ADDR_W'(MEM_DEPTH);
  assign bus_idx  = addr_i[WORD_LSB +: IDX_W];
  assign bus_rd   = (state_q == READY) && req_i && !we_i;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    arr_en     = 1'b0;
    arr_we     = 1'b0;
    arr_idx    = bus_idx;
    arr_be     = be_i;
    arr_d      = wdata_i;
    err_set    = 1'b0;
    unique case (state_q)
      INIT: begin
        arr_en     = INIT_ZERO;
        arr_we     = 1'b1;
        arr_idx    = init_cnt_q;
        arr_be     = '1;
        arr_d      = '0;
        init_cnt_d = init_cnt_q + IDX_W'(1);
        if (!INIT_ZERO || init_cnt_q == IDX_W'(MEM_DEPTH - 1)) state_d = READY;
      end
      READY: begin
        if (req_i) begin
          if (in_range) begin
            arr_en = 1'b1;
            arr_we = we_i;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // rzero_q masks the array output after reset and after an out-of-range read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rzero_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= (state_d == READY);
      rvalid_q   <= bus_rd;
      err_q      <= err_set || (err_q && !err_clr_i);
      if (bus_rd) rzero_q <= !in_range;
    end
  end

  peripheral_spram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk_i(clk_i),
    .en_i (arr_en),
    .we_i (arr_we),
    .idx_i(arr_idx),
    .be_i (arr_be),
    .d_i  (arr_d),
    .q_o  (arr_q)
  );

  assign rdata_o  = rzero_q ? '0 : arr_q;
  assign rvalid_o = rvalid_q;
  assign ready_o  = ready_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_peripheral_spram_mem_ctrl.sv
// Directed vector bench for peripheral_spram_mem_ctrl with MEM_DEPTH=16, 64-bit words.
`timescale 1ns/1ps
module tb_peripheral_spram_mem_ctrl;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NV = 39;

  typedef struct {
    logic        req;
    logic        we;
    logic        clr;
    logic [63:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic        exp_rvalid;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, req, we, err_clr;
  logic [AW-1:0] addr;
  logic [7:0]    be;
  logic [DW-1:0] wdata, rdata;
  logic          rvalid, ready, err;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [NV];

  peripheral_spram_mem_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(16), .INIT_ZERO(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .be_i(be),
    .wdata_i(wdata), .rdata_o(rdata), .rvalid_o(rvalid), .ready_o(ready),
    .err_o(err), .err_clr_i(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic c, input logic [63:0] a,
                       input logic [7:0] b, input logic [63:0] d);
    req = r; we = w; err_clr = c; addr = a; be = b; wdata = d;
  endtask

  function automatic vec_t v(input logic r, input logic w, input logic c, input logic [63:0] a,
                             input logic [7:0] b, input logic [63:0] d,
                             input logic erv, input logic [63:0] erd, input logic eer);
    vec_t t;
    t.req = r; t.we = w; t.clr = c; t.addr = a; t.be = b; t.wdata = d;
    t.exp_rvalid = erv; t.exp_rdata = erd; t.exp_err = eer;
    return t;
  endfunction

  // Counts cycles with ready_o low; optionally pokes requests that must be ignored.
  task automatic wait_ready(input bit poke, output int cycles);
    cycles = 0;
    while (!ready && cycles < 100) begin
      if (poke && cycles[0]) drive(1, 0, 0, 64'h80, 8'hFF, 64'h0);
      else if (poke)         drive(1, 1, 0, 64'h08, 8'hFF, 64'hA5A5_5A5A_1234_5678);
      cycles++;
      step();
      if (poke) begin
        chk("init_rvalid", 64'(rvalid), 64'd0);
        chk("init_err", 64'(err), 64'd0);
      end
    end
    drive(0, 0, 0, 64'h0, 8'h00, 64'h0);
  endtask

  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] MIX  = 64'h1122_3344_BBBB_BBBB;
  localparam logic [63:0] TOP  = 64'h0F0E_0D0C_0B0A_0908;

  initial begin
    int cyc;
    for (int i = 0; i < 16; i++) vecs[i] = v(1, 0, 0, 64'(i * 8), 8'h00, 64'h0, 1, 64'h0, 0);
    vecs[16] = v(0, 0, 0, 64'h00, 8'h00, 64'h0,                  0, 64'h0, 0);
    vecs[17] = v(1, 1, 0, 64'h18, 8'hFF, 64'h1122_3344_5566_7788, 0, 64'h0, 0);
    vecs[18] = v(1, 1, 0, 64'h18, 8'h0F, 64'hAAAA_AAAA_BBBB_BBBB, 0, 64'h0, 0);
    vecs[19] = v(1, 0, 0, 64'h18, 8'h00, 64'h0,                  1, MIX,   0);
    vecs[20] = v(1, 1, 0, 64'h08, 8'hFF, DEAD,                   0, MIX,   0);
    vecs[21] = v(1, 0, 0, 64'h08, 8'h00, 64'h0,                  1, DEAD,  0);
    vecs[22] = v(1, 0, 0, 64'h08, 8'h00, 64'h0,                  1, DEAD,  0);
    vecs[23] = v(1, 0, 0, 64'h08, 8'h00, 64'h0,                  1, DEAD,  0);
    vecs[24] = v(0, 0, 0, 64'h08, 8'h00, 64'h0,                  0, DEAD,  0);
    vecs[25] = v(1, 1, 0, 64'h08, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, DEAD,  0);
    vecs[26] = v(1, 0, 0, 64'h08, 8'h00, 64'h0,                  1, DEAD,  0);
    vecs[27] = v(1, 1, 0, 64'h80, 8'hFF, 64'h5555_5555_5555_5555, 0, DEAD,  1);
    vecs[28] = v(1, 0, 0, 64'h00, 8'h00, 64'h0,                  1, 64'h0, 1);
    vecs[29] = v(1, 0, 0, 64'h08, 8'h00, 64'h0,                  1, DEAD,  1);
    vecs[30] = v(1, 0, 0, 64'h80, 8'h00, 64'h0,                  1, 64'h0, 1);
    vecs[31] = v(0, 0, 1, 64'h00, 8'h00, 64'h0,                  0, 64'h0, 0);
    vecs[32] = v(1, 0, 1, 64'h80, 8'h00, 64'h0,                  1, 64'h0, 1);
    vecs[33] = v(0, 0, 1, 64'h00, 8'h00, 64'h0,                  0, 64'h0, 0);
    vecs[34] = v(1, 1, 0, 64'h78, 8'hFF, TOP,                    0, 64'h0, 0);
    vecs[35] = v(1, 0, 0, 64'h78, 8'h00, 64'h0,                  1, TOP,   0);
    vecs[36] = v(1, 0, 0, 64'h0000_0001_0000_0078, 8'h00, 64'h0, 1, 64'h0, 1);
    vecs[37] = v(0, 0, 1, 64'h00, 8'h00, 64'h0,                  0, 64'h0, 0);
    vecs[38] = v(1, 0, 0, 64'h18, 8'h00, 64'h0,                  1, MIX,   0);

    rst = 1'b1;
    drive(0, 0, 0, 64'h0, 8'h00, 64'h0);
    step();
    step();
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    wait_ready(0, cyc);
    chk("init_cycles", 64'(cyc), 64'd16);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].clr, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      step();
      chk($sformatf("v%0d_rvalid", i), 64'(rvalid), 64'(vecs[i].exp_rvalid));
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
    end
    drive(0, 0, 0, 64'h0, 8'h00, 64'h0);

    // Abort a clear at init_cnt=7, then restart it while poking requests.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (7) step();
    chk("mid_ready", 64'(ready), 64'd0);
    rst = 1'b1;
    step();
    chk("rst2_ready", 64'(ready), 64'd0);
    chk("rst2_rvalid", 64'(rvalid), 64'd0);
    chk("rst2_rdata", rdata, 64'h0);
    rst = 1'b0;
    wait_ready(1, cyc);
    chk("restart_cycles", 64'(cyc), 64'd16);
    drive(1, 0, 0, 64'h18, 8'h00, 64'h0);
    step();
    chk("word3_cleared", rdata, 64'h0);
    chk("word3_rvalid", 64'(rvalid), 64'd1);
    drive(1, 0, 0, 64'h08, 8'h00, 64'h0);
    step();
    chk("init_write_ignored", rdata, 64'h0);
    chk("post_init_err", 64'(err), 64'd0);
    drive(0, 0, 0, 64'h0, 8'h00, 64'h0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
